// File: rtl/recv_packet_pkg.sv
// recv_packet_pkg: shared state types and sizing helpers for the multi-frame UART receiver
package recv_packet_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction
   function automatic int timeout_cycles(input int frames, input int frame_size, input int ratio);
      return frames * (frame_size + 2) * ratio;
   endfunction
endpackage

// File: rtl/recv_packet_rx_frame.sv
// rx_frame: single-frame UART deserialiser with input synchroniser, mid-bit start check and stop-bit check
module rx_frame
   import recv_packet_pkg::*;
#(
   parameter int CLK_BAUD_RATIO = 25,
   parameter int FRAME_SIZE = 8
) (
   input logic clk_in,
   input logic rst_n_in,
   input logic rx_in,
   output logic [FRAME_SIZE-1:0] data_out,
   output logic new_frame_out,
   output logic frame_err_out
);
   localparam int CBW = $clog2(CLK_BAUD_RATIO);
   localparam int BW = FRAME_SIZE > 1 ? $clog2(FRAME_SIZE) : 1;
   rx_state_e state_q, state_d;
   logic [2:0] sync_q, sync_d;
   logic [CBW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [FRAME_SIZE-1:0] shift_q, shift_d;
   logic done_q, done_d, err_q, err_d;
   logic rx_s, tick, half;
   assign rx_s = sync_q[1];
   assign tick = cnt_q == CBW'(CLK_BAUD_RATIO - 1);
   assign half = cnt_q == CBW'(CLK_BAUD_RATIO / 2 - 1);
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         state_q <= RX_IDLE;
         sync_q  <= 3'b111;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   // start only on a falling edge, so a line held low after a bad stop bit is not re-read as a frame
   always_comb
      state_d = state_q == RX_IDLE  ? (sync_q[2] && !rx_s ? RX_START : RX_IDLE)
              : state_q == RX_START ? (half ? (rx_s ? RX_IDLE : RX_DATA) : RX_START)
              : state_q == RX_DATA  ? (tick && bit_q == BW'(FRAME_SIZE - 1) ? RX_STOP : RX_DATA)
              : (tick ? RX_IDLE : RX_STOP);
   always_comb begin
      sync_d  = {sync_q[1:0], rx_in};
      cnt_d   = (state_q == RX_IDLE || (state_q == RX_START && half) || tick) ? '0 : cnt_q + 1'b1;
      bit_d   = state_q == RX_START ? '0 : (state_q == RX_DATA && tick) ? bit_q + 1'b1 : bit_q;
      shift_d = (state_q == RX_DATA && tick) ? {rx_s, shift_q[FRAME_SIZE-1:1]} : shift_q;
      done_d  = state_q == RX_STOP && tick && rx_s;
      err_d   = state_q == RX_STOP && tick && !rx_s;
   end
   assign data_out = shift_q;
   assign new_frame_out = done_q;
   assign frame_err_out = err_q;
endmodule

// File: rtl/recv_packet.sv
// recv_packet: multi-frame UART receiver assembling frames into one wide word with valid/ready handoff
module recv_packet
   import recv_packet_pkg::*;
#(
   parameter int CLK_BAUD_RATIO = 25,
   parameter int FRAME_SIZE = 8,
   parameter int MAX_FRAMES = 4,
   parameter int TIMEOUT_FRAMES = 2,
   parameter bit MSB_FIRST = 1'b0,
   localparam int DATA_SIZE = FRAME_SIZE * MAX_FRAMES,
   localparam int CW = cnt_width(MAX_FRAMES)
) (
   input logic clk_in,
   input logic rst_n_in,
   input logic rx_in,
   input logic receive_in,
   input logic [CW-1:0] frames_in,
   output logic [DATA_SIZE-1:0] data_out,
   output logic [CW-1:0] count_out,
   output logic valid_out,
   input logic ready_in,
   output logic busy_out,
   output logic frame_err_out,
   output logic timeout_out,
   output logic overrun_out
);
   localparam int TO = timeout_cycles(TIMEOUT_FRAMES, FRAME_SIZE, CLK_BAUD_RATIO);
   localparam int TW = cnt_width(TO);
   state_e state_q, state_d;
   logic [CW-1:0] len_q, len_d, idx_q, idx_d, count_q, count_d, slot;
   logic [DATA_SIZE-1:0] buf_q, buf_d, data_q, data_d, merged;
   logic [TW-1:0] gap_q, gap_d;
   logic armed_q, armed_d, valid_q, valid_d, ferr_q, ferr_d, to_q, to_d, ovr_q, ovr_d;
   logic rst_meta_q, rst_sync_q, rst_n;
   logic [FRAME_SIZE-1:0] rx_data;
   logic new_frame, frame_err, req, frm, last, err, expire, hs;
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) {rst_meta_q, rst_sync_q} <= 2'b00;
      else {rst_meta_q, rst_sync_q} <= {1'b1, rst_meta_q};
   assign rst_n = rst_sync_q;
   rx_frame #(.CLK_BAUD_RATIO(CLK_BAUD_RATIO), .FRAME_SIZE(FRAME_SIZE)) u_rx (
      .clk_in(clk_in),
      .rst_n_in(rst_n),
      .rx_in(rx_in),
      .data_out(rx_data),
      .new_frame_out(new_frame),
      .frame_err_out(frame_err)
   );
   always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         count_q <= '0;
         buf_q   <= '0;
         data_q  <= '0;
         gap_q   <= '0;
         armed_q <= 1'b0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         to_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         buf_q   <= buf_d;
         data_q  <= data_d;
         gap_q   <= gap_d;
         armed_q <= armed_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         to_q    <= to_d;
         ovr_q   <= ovr_d;
      end
   // an arriving frame beats a same-cycle timeout expiry
   always_comb begin
      req    = state_q == IDLE && receive_in && frames_in != '0;
      frm    = state_q == COLLECT && new_frame;
      last   = frm && idx_q == len_q - 1'b1;
      err    = state_q == COLLECT && frame_err;
      expire = state_q == COLLECT && armed_q && !new_frame && !frame_err && gap_q + 1'b1 == TW'(TO);
      hs     = state_q == HOLD && valid_q && ready_in;
   end
   always_comb
      state_d = state_q == IDLE    ? (req ? COLLECT : IDLE)
              : state_q == COLLECT ? ((err || expire) ? IDLE : last ? HOLD : COLLECT)
              : state_q == HOLD    ? (hs ? IDLE : HOLD)
              : IDLE;
   always_comb begin
      slot    = MSB_FIRST ? len_q - 1'b1 - idx_q : idx_q;
      merged  = buf_q;
      merged[slot*FRAME_SIZE +: FRAME_SIZE] = rx_data;
      len_d   = req ? (frames_in > CW'(MAX_FRAMES) ? CW'(MAX_FRAMES) : frames_in) : len_q;
      idx_d   = req ? '0 : frm ? idx_q + 1'b1 : idx_q;
      buf_d   = req ? '0 : frm ? merged : buf_q;
      data_d  = last ? merged : data_q;
      count_d = last ? len_q : count_q;
      valid_d = last || (valid_q && !hs);
      gap_d   = req ? '0 : frm ? TW'(1) : (state_q == COLLECT && armed_q) ? gap_q + 1'b1 : gap_q;
      armed_d = req ? 1'b0 : frm ? 1'b1 : armed_q;
      ferr_d  = err;
      to_d    = expire;
      ovr_d   = state_q == HOLD && new_frame;
   end
   assign data_out      = data_q;
   assign count_out     = count_q;
   assign valid_out     = valid_q;
   assign busy_out      = state_q != IDLE;
   assign frame_err_out = ferr_q;
   assign timeout_out   = to_q;
   assign overrun_out   = ovr_q;
endmodule

// File: tb/tb_recv_packet.sv
// tb_recv_packet: randomized self-checking bench for recv_packet against a frame-packing model
module tb_recv_packet;
   localparam int R = 25;
   logic clk_in = 1'b0, rst_n_in = 1'b1, rx_in = 1'b1, receive_in = 1'b0, ready_in = 1'b0;
   logic [2:0] frames_in = '0;
   logic [31:0] data_l, data_m;
   logic [2:0] count_l, count_m;
   logic valid_l, busy_l, ferr_l, to_l, ovr_l, valid_m, busy_m, ferr_m, to_m, ovr_m;
   int vectors = 0, miscompares = 0;
   int cyc = 0, last_nf = 0, vrise = 0, to_cyc = 0, n_ferr = 0, n_to = 0, n_ovr = 0, vcycles = 0;
   logic v_prev = 1'b0;
   always #5 clk_in = ~clk_in;
   recv_packet #(.MSB_FIRST(1'b0)) dut_l (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rx_in(rx_in), .receive_in(receive_in),
      .frames_in(frames_in), .data_out(data_l), .count_out(count_l), .valid_out(valid_l),
      .ready_in(ready_in), .busy_out(busy_l), .frame_err_out(ferr_l), .timeout_out(to_l),
      .overrun_out(ovr_l));
   recv_packet #(.MSB_FIRST(1'b1)) dut_m (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rx_in(rx_in), .receive_in(receive_in),
      .frames_in(frames_in), .data_out(data_m), .count_out(count_m), .valid_out(valid_m),
      .ready_in(ready_in), .busy_out(busy_m), .frame_err_out(ferr_m), .timeout_out(to_m),
      .overrun_out(ovr_m));
   always @(posedge clk_in) cyc <= cyc + 1;
   always @(negedge clk_in) begin
      v_prev <= valid_l;
      if (dut_l.new_frame) last_nf <= cyc;
      if (valid_l && !v_prev) vrise <= cyc;
      if (valid_l) vcycles <= vcycles + 1;
      if (ferr_l) n_ferr <= n_ferr + 1;
      if (ovr_l) n_ovr <= n_ovr + 1;
      if (to_l) begin
         n_to <= n_to + 1;
         to_cyc <= cyc;
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1);
   end
   function automatic logic [31:0] pack(input logic [7:0] b [4], input int n, input bit msb);
      logic [31:0] acc = '0;
      for (int k = 0; k < n; k++) acc = msb ? {acc[23:0], b[k]} : acc | ({24'd0, b[k]} << (8 * k));
      return acc;
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic request(input int n);
      @(negedge clk_in);
      receive_in = 1'b1;
      frames_in = 3'(n);
      @(negedge clk_in);
      receive_in = 1'b0;
      frames_in = '0;
   endtask
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx_in = 1'b0;
      repeat (R) @(negedge clk_in);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         repeat (R) @(negedge clk_in);
      end
      rx_in = stop;
      repeat (R) @(negedge clk_in);
      rx_in = 1'b1;
      repeat (2) @(negedge clk_in);
   endtask
   task automatic wait_valid();
      int n = 0;
      while (!valid_l && n < 600) begin
         @(negedge clk_in);
         n++;
      end
      chk("valid_seen", valid_l, 1);
   endtask
   task automatic run_packet(input int req, input logic [7:0] b [4], input bit early);
      int n = req > 4 ? 4 : req;
      int v0 = vcycles;
      logic [31:0] el = pack(b, n, 1'b0);
      logic [31:0] em = pack(b, n, 1'b1);
      ready_in = early;
      request(req);
      for (int k = 0; k < n; k++) send_frame(b[k], 1'b1);
      repeat (2) @(negedge clk_in);
      if (!early) wait_valid();
      chk("data_lsb", data_l, el);
      chk("data_msb", data_m, em);
      chk("count_l", count_l, n);
      chk("count_m", count_m, n);
      chk("valid_latency", vrise - last_nf, 1);
      if (early) begin
         chk("early_valid_cycles", vcycles - v0, 1);
         chk("early_busy", busy_l, 0);
      end else chk("hold_busy", busy_l, 1);
      ready_in = 1'b0;
   endtask
   task automatic handshake(input logic [31:0] el);
      ready_in = 1'b1;
      @(negedge clk_in);
      ready_in = 1'b0;
      chk("hs_valid", valid_l, 0);
      chk("hs_valid_m", valid_m, 0);
      chk("hs_busy", busy_l, 0);
      chk("hs_data_hold", data_l, el);
   endtask
   initial begin
      logic [7:0] b [4];
      int f0, o0, t0, v0, n;
      bit e;
      #2 rst_n_in = 1'b0;
      #1;
      chk("rst_data", data_l, 0);
      chk("rst_count", count_l, 0);
      chk("rst_valid", valid_l, 0);
      chk("rst_busy", busy_l, 0);
      chk("rst_pulses", {ferr_l, to_l, ovr_l}, 0);
      #20 rst_n_in = 1'b1;
      repeat (4) @(negedge clk_in);
      b = '{8'h34, 8'h12, 8'h00, 8'h00};
      run_packet(2, b, 1'b0);
      chk("lsb_1234", data_l, 32'h0000_1234);
      handshake(32'h0000_1234);
      b = '{8'hAA, 8'hBB, 8'hCC, 8'h00};
      run_packet(3, b, 1'b0);
      chk("msb_aabbcc", data_m, 32'h00AA_BBCC);
      handshake(32'h00CC_BBAA);
      foreach (b[i]) b[i] = 8'($urandom);
      run_packet(4, b, 1'b0);
      repeat (300) @(negedge clk_in);
      o0 = n_ovr;
      send_frame(8'h55, 1'b1);
      repeat (3) @(negedge clk_in);
      chk("overrun_pulses", n_ovr - o0, 1);
      chk("overrun_data", data_l, pack(b, 4, 1'b0));
      chk("overrun_valid", valid_l, 1);
      handshake(pack(b, 4, 1'b0));
      f0 = n_ferr;
      v0 = vcycles;
      request(3);
      send_frame(8'h5A, 1'b1);
      send_frame(8'hA5, 1'b0);
      repeat (50) @(negedge clk_in);
      chk("ferr_pulses", n_ferr - f0, 1);
      chk("ferr_busy", busy_l, 0);
      chk("ferr_no_valid", vcycles - v0, 0);
      foreach (b[i]) b[i] = 8'($urandom);
      run_packet(3, b, 1'b0);
      handshake(pack(b, 3, 1'b0));
      t0 = n_to;
      request(3);
      repeat (1200) @(negedge clk_in);
      chk("no_timeout_before_first", n_to - t0, 0);
      chk("wait_busy", busy_l, 1);
      send_frame(8'h77, 1'b1);
      n = 0;
      while (n_to == t0 && n < 700) begin
         @(negedge clk_in);
         n++;
      end
      repeat (2) @(negedge clk_in);
      chk("timeout_gap", to_cyc - last_nf, 500);
      chk("timeout_pulses", n_to - t0, 1);
      chk("timeout_busy", busy_l, 0);
      request(0);
      repeat (5) @(negedge clk_in);
      chk("zero_req_busy", busy_l, 0);
      request(3);
      send_frame(8'h3C, 1'b1);
      @(negedge clk_in);
      #2 rst_n_in = 1'b0;
      #1;
      chk("midrst_busy", busy_l, 0);
      chk("midrst_data", data_l, 0);
      chk("midrst_count", count_l, 0);
      chk("midrst_valid", valid_l, 0);
      #3 rst_n_in = 1'b1;
      repeat (4) @(negedge clk_in);
      foreach (b[i]) b[i] = 8'($urandom);
      run_packet(7, b, 1'b0);
      chk("clamp_count", count_l, 4);
      handshake(pack(b, 4, 1'b0));
      send_frame(8'($urandom), 1'b1);
      for (int i = 0; i < 6; i++) begin
         foreach (b[j]) b[j] = 8'($urandom);
         n = $urandom_range(1, 4);
         e = $urandom_range(0, 1) == 1;
         run_packet(n, b, e);
         if (!e) handshake(pack(b, n, 1'b0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
